// File: rtl/pong_menu_pkg.sv
// Shared types and text-geometry constants for the Pong menu controller.
package pong_menu_pkg;

  typedef enum logic [1:0] {
    ST_MENU = 2'd0,
    ST_PLAY = 2'd1,
    ST_OVER = 2'd2
  } state_t;

  localparam int unsigned GLYPH_W   = 8;
  localparam int unsigned GLYPH_H   = 16;
  localparam int unsigned TEXT_COLS = 16;
  localparam int unsigned TEXT_ROWS = 2;

  localparam int unsigned WIN_W = GLYPH_W * TEXT_COLS;
  localparam int unsigned WIN_H = GLYPH_H * TEXT_ROWS;

endpackage

// File: rtl/menu_text_addr.sv
// Maps the scan position onto the 16x2 text window and registers the
// character-ROM address, glyph row/column and text_on one cycle later.
module menu_text_addr #(
  parameter int unsigned TEXT_X0 = 256,
  parameter int unsigned TEXT_Y0 = 208
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] pixel_x,
  input  logic [9:0] pixel_y,
  input  logic       video_on,
  input  logic       show,
  output logic [7:0] char_xy,
  output logic [3:0] row_addr,
  output logic [2:0] bit_addr,
  output logic       text_on
);
  import pong_menu_pkg::*;

  localparam logic [9:0] X0 = 10'(TEXT_X0);
  localparam logic [9:0] Y0 = 10'(TEXT_Y0);

  logic [9:0] dx;
  logic [9:0] dy;
  logic       in_win;

  // The >= test guards against the subtraction wrapping below the origin.
  always_comb begin
    dx     = pixel_x - X0;
    dy     = pixel_y - Y0;
    in_win = (pixel_x >= X0) && (dx < 10'(WIN_W)) &&
             (pixel_y >= Y0) && (dy < 10'(WIN_H));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      char_xy  <= '0;
      row_addr <= '0;
      bit_addr <= '0;
      text_on  <= 1'b0;
    end else begin
      if (in_win) begin
        char_xy  <= {3'b000, dy[4], dx[6:3]};
        row_addr <= dy[3:0];
        bit_addr <= dx[2:0];
      end else begin
        char_xy  <= '0;
        row_addr <= '0;
        bit_addr <= '0;
      end
      text_on <= in_win && video_on && show;
    end
  end

endmodule

// File: rtl/pong_menu_ctrl.sv
// Pong menu/game-state controller: MENU -> PLAY -> OVER -> MENU with difficulty select.
// Define PONG_DIFF_PERSIST_EN to keep the chosen difficulty across games.
module pong_menu_ctrl #(
  parameter int unsigned TEXT_X0     = 256,
  parameter int unsigned TEXT_Y0     = 208,
  parameter int unsigned OVER_FRAMES = 120
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_sel,
  input  logic       game_over,
  input  logic       frame_tick,
  input  logic [9:0] pixel_x,
  input  logic [9:0] pixel_y,
  input  logic       video_on,
  output logic [7:0] char_xy,
  output logic [3:0] row_addr,
  output logic [2:0] bit_addr,
  output logic       text_on,
  output logic       difficulty,
  output logic       game_start,
  output logic       menu_active
);
  import pong_menu_pkg::*;

  localparam int unsigned     CNT_W = $clog2(OVER_FRAMES + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(OVER_FRAMES - 1);

  state_t           state;
  state_t           state_next;
  logic             difficulty_next;
  logic             start_next;
  logic [CNT_W-1:0] frames;
  logic [CNT_W-1:0] frames_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_MENU;
      difficulty <= 1'b0;
      frames     <= '0;
      game_start <= 1'b0;
    end else begin
      state      <= state_next;
      difficulty <= difficulty_next;
      frames     <= frames_next;
      game_start <= start_next;
    end
  end

  always_comb begin
    state_next      = state;
    difficulty_next = difficulty;
    frames_next     = frames;
    start_next      = 1'b0;
    case (state)
      ST_MENU: begin
        // Select wins over a simultaneous up/down; up+down together cancel.
        if (btn_sel) begin
          state_next = ST_PLAY;
          start_next = 1'b1;
        end else if (btn_up != btn_down) begin
          difficulty_next = btn_up;
        end
      end
      ST_PLAY: begin
        if (game_over) begin
          state_next  = ST_OVER;
          frames_next = '0;
        end
      end
      ST_OVER: begin
        if (frame_tick) frames_next = frames + CNT_W'(1);
        if (btn_sel || (frame_tick && frames == LAST)) begin
          state_next = ST_MENU;
`ifndef PONG_DIFF_PERSIST_EN
          difficulty_next = 1'b0;
`endif
        end
      end
      default: state_next = ST_MENU;
    endcase
  end

  assign menu_active = (state == ST_MENU);

  menu_text_addr #(
    .TEXT_X0(TEXT_X0),
    .TEXT_Y0(TEXT_Y0)
  ) u_text_addr (
    .clk      (clk),
    .reset    (reset),
    .pixel_x  (pixel_x),
    .pixel_y  (pixel_y),
    .video_on (video_on),
    .show     (state != ST_PLAY),
    .char_xy  (char_xy),
    .row_addr (row_addr),
    .bit_addr (bit_addr),
    .text_on  (text_on)
  );

endmodule

// File: tb/tb_pong_menu_ctrl.sv
// Scoreboard bench for pong_menu_ctrl: directed scenarios then random stimulus.
module tb_pong_menu_ctrl;
  localparam int X0 = 256;
  localparam int Y0 = 208;
  localparam int NF = 120;
`ifdef PONG_DIFF_PERSIST_EN
  localparam bit PERSIST = 1'b1;
`else
  localparam bit PERSIST = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset, btn_up, btn_down, btn_sel, game_over, frame_tick, video_on;
  logic [9:0] pixel_x, pixel_y;
  logic [7:0] char_xy;
  logic [3:0] row_addr;
  logic [2:0] bit_addr;
  logic       text_on, difficulty, game_start, menu_active;

  always #5 clk = ~clk;

  pong_menu_ctrl #(
    .TEXT_X0(X0),
    .TEXT_Y0(Y0),
    .OVER_FRAMES(NF)
  ) dut (
    .clk(clk), .reset(reset), .btn_up(btn_up), .btn_down(btn_down),
    .btn_sel(btn_sel), .game_over(game_over), .frame_tick(frame_tick),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .video_on(video_on),
    .char_xy(char_xy), .row_addr(row_addr), .bit_addr(bit_addr),
    .text_on(text_on), .difficulty(difficulty), .game_start(game_start),
    .menu_active(menu_active)
  );

  typedef struct {
    logic [7:0] cxy;
    logic [3:0] row;
    logic [2:0] bits;
    logic       ton;
    logic       diff;
    logic       start;
    logic       menu;
  } exp_t;

  exp_t        q[$];
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  string m_mode   = "MENU";
  bit    m_diff   = 1'b0;
  int    m_frames = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Monitor: one expectation is due one cycle after each stimulus cycle.
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check("char_xy",     char_xy,           e.cxy);
        check("row_addr",    {4'h0, row_addr},  {4'h0, e.row});
        check("bit_addr",    {5'h0, bit_addr},  {5'h0, e.bits});
        check("text_on",     {7'h0, text_on},   {7'h0, e.ton});
        check("difficulty",  {7'h0, difficulty},{7'h0, e.diff});
        check("game_start",  {7'h0, game_start},{7'h0, e.start});
        check("menu_active", {7'h0, menu_active},{7'h0, e.menu});
      end
    end
  end

  // Reference model: evaluates the rules for the current inputs, pushes the
  // expected post-edge outputs, then advances one clock and clears pulses.
  task automatic cycle();
    exp_t  e;
    string prev;
    int    dx, dy;
    bit    inw, leave;
    prev    = m_mode;
    e.start = 1'b0;
    if (reset) begin
      m_mode   = "MENU";
      m_diff   = 1'b0;
      m_frames = 0;
    end else if (prev == "MENU") begin
      if (btn_sel) begin
        m_mode  = "PLAY";
        e.start = 1'b1;
      end else if (btn_up && !btn_down) m_diff = 1'b1;
      else if (btn_down && !btn_up) m_diff = 1'b0;
    end else if (prev == "PLAY") begin
      if (game_over) begin
        m_mode   = "OVER";
        m_frames = 0;
      end
    end else begin
      leave = btn_sel;
      if (frame_tick) begin
        m_frames++;
        if (m_frames == NF) leave = 1'b1;
      end
      if (leave) begin
        m_mode = "MENU";
        if (!PERSIST) m_diff = 1'b0;
      end
    end
    dx  = int'(pixel_x) - X0;
    dy  = int'(pixel_y) - Y0;
    inw = (dx >= 0) && (dx < 128) && (dy >= 0) && (dy < 32);
    if (reset || !inw) begin
      e.cxy = 8'h00; e.row = 4'h0; e.bits = 3'h0;
    end else begin
      e.cxy  = 8'((dy / 16) * 16 + dx / 8);
      e.row  = 4'(dy % 16);
      e.bits = 3'(dx % 8);
    end
    e.ton  = !reset && inw && video_on && (prev != "PLAY");
    e.diff = m_diff;
    e.menu = (m_mode == "MENU");
    q.push_back(e);
    @(posedge clk);
    #2;
    reset = 0; btn_up = 0; btn_down = 0; btn_sel = 0; game_over = 0; frame_tick = 0;
  endtask

  task automatic set_px(input int x, input int y, input logic v);
    pixel_x  = 10'(x);
    pixel_y  = 10'(y);
    video_on = v;
  endtask

  initial begin
    reset = 0; btn_up = 0; btn_down = 0; btn_sel = 0; game_over = 0; frame_tick = 0;
    set_px(X0 + 5, Y0 + 3, 1'b1);
    @(posedge clk);
    #2;

    reset = 1; cycle();
    reset = 1; btn_up = 1; btn_sel = 1; cycle();
    cycle();
    btn_up = 1; cycle();
    btn_up = 1; btn_down = 1; cycle();
    btn_down = 1; cycle();
    btn_up = 1; cycle();

    set_px(X0 + 24, Y0 + 17, 1'b1); cycle();
    set_px(X0 + 128, Y0, 1'b1); cycle();
    set_px(X0 + 127, Y0 + 31, 1'b1); cycle();
    set_px(X0, Y0 + 32, 1'b1); cycle();
    set_px(X0 - 1, Y0, 1'b1); cycle();
    set_px(X0 + 60, Y0 + 20, 1'b0); cycle();
    set_px(X0 + 5, Y0 + 3, 1'b1);

    btn_sel = 1; btn_down = 1; cycle();
    cycle();
    btn_up = 1; cycle();
    btn_down = 1; cycle();
    btn_sel = 1; cycle();
    frame_tick = 1; cycle();

    game_over = 1; cycle();
    for (int t = 1; t <= NF; t++) begin
      frame_tick = 1; cycle();
      cycle();
    end
    cycle();

    btn_up = 1; cycle();
    btn_sel = 1; cycle();
    game_over = 1; cycle();
    for (int t = 1; t <= 5; t++) begin
      frame_tick = 1; cycle();
    end
    btn_sel = 1; cycle();
    cycle();

    btn_up = 1; cycle();
    btn_sel = 1; cycle();
    game_over = 1; cycle();
    frame_tick = 1; cycle();
    reset = 1; frame_tick = 1; cycle();
    cycle();

    for (int i = 0; i < 2500; i++) begin
      reset      = ($urandom_range(0, 299) == 0);
      btn_up     = ($urandom_range(0, 5) == 0);
      btn_down   = ($urandom_range(0, 5) == 0);
      btn_sel    = ($urandom_range(0, 29) == 0);
      game_over  = ($urandom_range(0, 15) == 0);
      frame_tick = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 9) == 0)
        set_px(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)), 1'b1);
      else
        set_px(int'($urandom_range(X0 - 3, X0 + 130)), int'($urandom_range(Y0 - 3, Y0 + 34)),
               logic'($urandom_range(0, 7) != 0));
      cycle();
    end

    for (int i = 0; i < 4 && q.size() > 0; i++) begin
      @(posedge clk);
      #2;
    end
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pong_menu_ctrl.md
PONG_MENU_CTRL -- requirements
Module: pong_menu_ctrl

Interface
REQ-001 Parameter TEXT_X0, default 256: left pixel column of the 16x2 text window.
REQ-002 Parameter TEXT_Y0, default 208: top pixel row of the text window.
REQ-003 Parameter OVER_FRAMES, default 120: frame_tick count spent in OVER before returning to MENU.
REQ-004 clk  in  1  system clock; single clock domain.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 btn_up, btn_down, btn_sel  in  1 each  debounced single-cycle button pulses.
REQ-007 game_over  in  1  single-cycle pulse from game logic.
REQ-008 frame_tick  in  1  single-cycle pulse, once per video frame.
REQ-009 pixel_x, pixel_y  in  10 each  current scan coordinates.
REQ-010 video_on  in  1  active-display flag.
REQ-011 char_xy  out  8  character address to the 16x2 difficulty character ROM.
REQ-012 row_addr  out  4  font row within the glyph (pixel_y offset mod 16).
REQ-013 bit_addr  out  3  font column within the glyph (pixel_x offset mod 8).
REQ-014 text_on  out  1  current pixel lies inside the displayed text window.
REQ-015 difficulty  out  1  0 = easy, 1 = hard; drives the ROM difficulty input and game logic.
REQ-016 game_start  out  1  single-cycle pulse on entry to PLAY.
REQ-017 menu_active  out  1  high while in MENU.

Function
REQ-018 FSM states MENU, PLAY and OVER SHALL be used.
REQ-019 MENU: btn_up SHALL set difficulty to 1 and btn_down SHALL set it to 0; btn_up and btn_down together SHALL leave it unchanged.
REQ-020 MENU plus btn_sel SHALL go to PLAY next cycle with game_start high for exactly that cycle; btn_sel takes priority over a concurrent btn_up/btn_down, whose effect SHALL be discarded.
REQ-021 PLAY: difficulty SHALL be frozen and all buttons ignored; game_over SHALL go to OVER and clear the frame counter.
REQ-022 OVER: the counter SHALL increment on frame_tick; at OVER_FRAMES-1 plus frame_tick, or on btn_sel, the FSM SHALL go to MENU.
REQ-023 Window: pixel_x in [TEXT_X0, TEXT_X0+127] and pixel_y in [TEXT_Y0, TEXT_Y0+31]; dx = pixel_x-TEXT_X0, dy = pixel_y-TEXT_Y0.
REQ-024 char_xy SHALL be {3'b000, dy[4], dx[6:3]}, row_addr dy[3:0], bit_addr dx[2:0]; outside the window all three SHALL be 0.
REQ-025 text_on SHALL be (in window) AND video_on AND (state is MENU or OVER).
REQ-026 char_xy, row_addr, bit_addr and text_on SHALL be registered with exactly 1-cycle latency from pixel_x/pixel_y/video_on, mutually aligned.
REQ-027 Window bounds SHALL be inclusive; coordinate TEXT_X0+128 or TEXT_Y0+32 SHALL give text_on = 0.

Reset
REQ-028 Reset SHALL force MENU, difficulty 0, frame counter 0, game_start 0, text_on 0, char_xy/row_addr/bit_addr 0 and menu_active 1 on the next edge, including reset asserted mid-PLAY or mid-OVER.
REQ-029 Input pulses coincident with reset SHALL be ignored.

Configuration
REQ-030 Macro PONG_DIFF_PERSIST_EN: when defined, difficulty SHALL persist across games through OVER->MENU.
REQ-031 Without PONG_DIFF_PERSIST_EN, the OVER->MENU transition SHALL clear difficulty to 0.

Structure
REQ-032 Package pong_menu_pkg SHALL hold the state encoding, glyph width 8, glyph height 16, text columns 16 and text rows 2.
REQ-033 Pixel-to-address mapping SHALL be a sub-module menu_text_addr (window compare, subtraction, output registers); the FSM stays in pong_menu_ctrl.

Verification
REQ-034 Reset, then btn_up -> difficulty=1 next cycle; btn_up+btn_down together -> difficulty unchanged.
REQ-035 MENU, btn_sel+btn_down with difficulty=1 -> PLAY, game_start high 1 cycle, difficulty stays 1.
REQ-036 pixel (TEXT_X0+24, TEXT_Y0+17) in MENU, video_on=1 -> one cycle later char_xy=8'h13, row_addr=1, bit_addr=0, text_on=1; pixel (TEXT_X0+128, TEXT_Y0) -> text_on=0.
REQ-037 PLAY, game_over, then 120 frame_ticks -> MENU exactly on the 120th tick; with btn_sel after tick 5 -> MENU immediately.
REQ-038 Reset asserted mid-OVER with difficulty=1 -> MENU, difficulty=0, text_on=0 next edge; bench runs both with and without PONG_DIFF_PERSIST_EN and checks difficulty after OVER->MENU.
